preamble_tx: RTL

Frame transmitter that serializes an NDATA-bit reference pattern (the preamble) followed by a fixed-length payload onto a single-bit line. It is the sending end of the correlation link: the receiver holds the same pattern as its reference word and correlates incoming bits against it at several lags to find frame alignment. Payload bytes arrive over a valid/ready byte interface and are sent MSB first behind the preamble. A fixed idle gap follows each frame.

---
 rtl/preamble_tx_pkg.sv | 32 +++
 rtl/preamble_tx_byte_serializer.sv | 100 ++++++++++
 rtl/preamble_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/preamble_tx_pkg.sv
// Shared definitions for the preamble correlation link:
// frame FSM states and counter widths used by both link ends.
package preamble_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GAP      = 2'd3
    } state_e;

    function automatic int ndata_log(input int ndata);
        return $clog2(ndata);
    endfunction

    function automatic int pre_cnt_w(input int ndata);
        return ndata_log(ndata) + 1;
    endfunction

    function automatic int pay_cnt_w(input int nbytes);
        return $clog2(8 * nbytes) + 1;
    endfunction

    function automatic int gap_cnt_w(input int ngap);
        return $clog2(ngap) + 1;
    endfunction

    function automatic int fetch_cnt_w(input int nbytes);
        return $clog2(nbytes) + 1;
    endfunction

endpackage

// File: rtl/preamble_tx_byte_serializer.sv
// Payload byte path: one-byte holding buffer feeding an 8-bit MSB-first
// shifter, with ready generation and per-stall underrun flag.
module byte_serializer
    import preamble_tx_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       fetch_en_i,
    input  logic       take_i,
    input  logic [7:0] din_i,
    input  logic       din_valid_i,
    output logic       din_ready_o,
    output logic       bit_avail_o,
    output logic       bit_o,
    output logic       underrun_o
);

    localparam int FW = fetch_cnt_w(NBYTES);
    localparam logic [FW-1:0] FETCH_MAX = FW'(NBYTES);

    logic [7:0]    hold_q, hold_d;
    logic          full_q, full_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [FW-1:0] fetched_q, fetched_d;
    logic          underrun_q, underrun_d;
    logic          hs;
    logic          sh_busy;
    logic          direct;

    assign din_ready_o = fetch_en_i && !full_q && (fetched_q < FETCH_MAX);
    assign hs          = din_valid_i && din_ready_o;
    assign sh_busy     = (cnt_q != 3'd0);
    assign bit_avail_o = sh_busy || full_q || hs;
    assign bit_o       = sh_busy ? sh_q[7] : (full_q ? hold_q[7] : din_i[7]);
    assign underrun_o  = underrun_q;

    // An arriving byte bypasses the buffer when the shifter needs it now.
    assign direct = take_i && !sh_busy && !full_q;

    always_comb begin
        hold_d     = hold_q;
        full_d     = full_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        fetched_d  = fetched_q;
        underrun_d = take_i && !bit_avail_o;

        if (hs) begin
            fetched_d = fetched_q + FW'(1);
        end

        if (take_i) begin
            if (sh_busy) begin
                sh_d  = {sh_q[6:0], 1'b0};
                cnt_d = cnt_q - 3'd1;
            end else if (full_q) begin
                sh_d   = {hold_q[6:0], 1'b0};
                cnt_d  = 3'd7;
                full_d = 1'b0;
            end else if (hs) begin
                sh_d  = {din_i[6:0], 1'b0};
                cnt_d = 3'd7;
            end
        end

        if (hs && !direct) begin
            hold_d = din_i;
            full_d = 1'b1;
        end

        if (clear_i) begin
            full_d    = 1'b0;
            cnt_d     = 3'd0;
            fetched_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= 8'd0;
            full_q     <= 1'b0;
            sh_q       <= 8'd0;
            cnt_q      <= 3'd0;
            fetched_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            full_q     <= full_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            fetched_q  <= fetched_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: rtl/preamble_tx.sv
// Frame transmitter: serial preamble, fixed-length payload, idle gap.
// Output registers always carry the bit for the current cycle.
module preamble_tx
    import preamble_tx_pkg::*;
#(
    parameter int NDATA  = 128,
    parameter int NBYTES = 4,
    parameter int NGAP   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NDATA-1:0] dinRef,
    input  logic [7:0]       dinPayload,
    input  logic             dinValid,
    output logic             dinReady,
    output logic             dout,
    output logic             doutValid,
    output logic             doutSof,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int PW = pre_cnt_w(NDATA);
    localparam int YW = pay_cnt_w(NBYTES);
    localparam int GW = gap_cnt_w(NGAP);
    localparam logic [PW-1:0] PRE_LAST  = PW'(NDATA);
    localparam logic [YW-1:0] PAY_TOTAL = YW'(8 * NBYTES);
    localparam logic [GW-1:0] GAP_LAST  = GW'(NGAP);

    state_e           state_q, state_d;
    logic [NDATA-1:0] sr_q, sr_d;
    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [YW-1:0]    pay_cnt_q, pay_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             done_q, done_d;
    logic             take;
    logic             clear;
    logic             fetch_en;
    logic             bit_avail;
    logic             bit_val;

    assign fetch_en = (state_q == PREAMBLE) || (state_q == PAYLOAD);

    byte_serializer #(
        .NBYTES(NBYTES)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .fetch_en_i (fetch_en),
        .take_i     (take),
        .din_i      (dinPayload),
        .din_valid_i(dinValid),
        .din_ready_o(dinReady),
        .bit_avail_o(bit_avail),
        .bit_o      (bit_val),
        .underrun_o (underrun)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        pre_cnt_d = pre_cnt_q;
        pay_cnt_d = pay_cnt_q;
        gap_cnt_d = gap_cnt_q;
        dout_d    = 1'b0;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        done_d    = 1'b0;
        take      = 1'b0;
        clear     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PREAMBLE;
                    sr_d      = {dinRef[NDATA-2:0], 1'b0};
                    dout_d    = dinRef[NDATA-1];
                    valid_d   = 1'b1;
                    sof_d     = 1'b1;
                    pre_cnt_d = PW'(1);
                    pay_cnt_d = '0;
                    gap_cnt_d = '0;
                    clear     = 1'b1;
                end
            end
            PREAMBLE: begin
                if (pre_cnt_q == PRE_LAST) begin
                    // Last preamble bit is on the line: fetch payload bit 0.
                    state_d = PAYLOAD;
                    take    = 1'b1;
                    if (bit_avail) begin
                        dout_d    = bit_val;
                        valid_d   = 1'b1;
                        pay_cnt_d = YW'(1);
                    end
                end else begin
                    dout_d    = sr_q[NDATA-1];
                    sr_d      = {sr_q[NDATA-2:0], 1'b0};
                    valid_d   = 1'b1;
                    pre_cnt_d = pre_cnt_q + PW'(1);
                end
            end
            PAYLOAD: begin
                if (pay_cnt_q == PAY_TOTAL) begin
                    state_d   = GAP;
                    gap_cnt_d = GW'(1);
                end else begin
                    take = 1'b1;
                    if (bit_avail) begin
                        dout_d    = bit_val;
                        valid_d   = 1'b1;
                        pay_cnt_d = pay_cnt_q + YW'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            pre_cnt_q <= '0;
            pay_cnt_q <= '0;
            gap_cnt_q <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            pre_cnt_q <= pre_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            done_q    <= done_d;
        end
    end

    assign dout      = dout_q;
    assign doutValid = valid_q;
    assign doutSof   = sof_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule
